// File: rtl/lcd_pkg.sv
// Shared types and packing constants for the HUB75 back-buffer loader.
// Pixels are RGB333 and four of them are packed into each 36-bit RAM word.
package lcd_pkg;

   typedef enum logic {
      S_FILL = 1'b0,
      S_FULL = 1'b1
   } state_t;

   localparam int R_W    = 3;
   localparam int G_W    = 3;
   localparam int B_W    = 3;
   localparam int PIX_W  = R_W + G_W + B_W;
   localparam int LANES  = 4;
   localparam int WORD_W = PIX_W * LANES;

   // Lane order matches the panel driver's column pairing, not the arrival order.
   localparam int LANE0_LSB = 9;
   localparam int LANE1_LSB = 0;
   localparam int LANE2_LSB = 27;
   localparam int LANE3_LSB = 18;

   function automatic logic [WORD_W-1:0] place_pixel(input logic [1:0] lane,
                                                     input logic [PIX_W-1:0] pix);
      logic [WORD_W-1:0] w;
      w = {{(WORD_W-PIX_W){1'b0}}, pix};
      case (lane)
         2'd0:    place_pixel = w << LANE0_LSB;
         2'd1:    place_pixel = w << LANE1_LSB;
         2'd2:    place_pixel = w << LANE2_LSB;
         2'd3:    place_pixel = w << LANE3_LSB;
         default: place_pixel = {WORD_W{1'b0}};
      endcase
   endfunction

endpackage

// File: rtl/pixel_packer.sv
// Gathers accepted pixels into lanes 0..3 of a 36-bit word.
// o_word is the word including the pixel currently being accepted; unfilled lanes are zero.
module pixel_packer
   import lcd_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_accept,
   input  logic [PIX_W-1:0]  i_pixel,
   input  logic              i_last,
   output logic              o_flush,
   output logic [WORD_W-1:0] o_word
);

   logic [1:0]        lane_q, lane_d;
   logic [WORD_W-1:0] acc_q,  acc_d;

   always_comb begin
      o_word  = acc_q | place_pixel(lane_q, i_pixel);
      o_flush = i_accept && ((lane_q == 2'd3) || i_last);
      lane_d  = lane_q;
      acc_d   = acc_q;
      if (i_clear) begin
         lane_d = 2'd0;
         acc_d  = {WORD_W{1'b0}};
      end else if (o_flush) begin
         // Clearing here is what zero-fills the lanes of a short final word.
         lane_d = 2'd0;
         acc_d  = {WORD_W{1'b0}};
      end else if (i_accept) begin
         lane_d = lane_q + 2'd1;
         acc_d  = o_word;
      end else begin
         lane_d = lane_q;
         acc_d  = acc_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lane_q <= 2'd0;
         acc_q  <= {WORD_W{1'b0}};
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: rtl/frame_loader.sv
// Back-buffer write sequencer: packs RGB333 pixels into 36-bit words and writes
// them into the frame RAM the display is not reading, following buffer swaps.
module frame_loader
   import lcd_pkg::*;
#(
   parameter int WORDS_PER_FRAME = 3360,
   parameter int ADDR_W          = 12
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [PIX_W-1:0]  s_pixel,
   input  logic              s_last,
   input  logic              i_require_data,
   output logic              o_wr_bank,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_addr_write,
   output logic [WORD_W-1:0] o_data_line,
   output logic              o_frame_done,
   output logic [7:0]        o_underrun_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_FRAME - 1);

   state_t            state_q,    state_d;
   logic              req_q,      req_d;
   logic              bank_q,     bank_d;
   logic              wr_en_q,    wr_en_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [WORD_W-1:0] data_q,     data_d;
   logic              done_q,     done_d;
   logic [7:0]        underrun_q, underrun_d;

   logic              swap_evt;
   logic              accept;
   logic              flush;
   logic [WORD_W-1:0] word;

   // Holding ready low during a swap means no pixel is accepted into a word about to be discarded.
   assign swap_evt = i_require_data ^ req_q;
   assign s_ready  = ~i_rst & (state_q == S_FILL) & ~swap_evt;
   assign accept   = s_valid & s_ready;

   pixel_packer u_packer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (swap_evt),
      .i_accept(accept),
      .i_pixel (s_pixel),
      .i_last  (s_last),
      .o_flush (flush),
      .o_word  (word)
   );

   always_comb begin
      state_d    = state_q;
      req_d      = i_require_data;
      bank_d     = bank_q;
      wr_en_d    = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      done_d     = 1'b0;
      underrun_d = underrun_q;

      // The address steps after each strobe, except the frame's last one, so it never passes LAST_ADDR.
      if (wr_en_q && !done_q) begin
         addr_d = addr_q + ADDR_W'(1);
      end else begin
         addr_d = addr_q;
      end

      if (flush) begin
         wr_en_d = 1'b1;
         data_d  = word;
         if ((addr_q == LAST_ADDR) || s_last) begin
            done_d  = 1'b1;
            state_d = S_FULL;
         end else begin
            state_d = state_q;
         end
      end else begin
         data_d = data_q;
      end

      if (swap_evt) begin
         bank_d  = ~bank_q;
         addr_d  = {ADDR_W{1'b0}};
         state_d = S_FILL;
         if ((state_q == S_FILL) && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
         end else begin
            underrun_d = underrun_q;
         end
      end else begin
         bank_d = bank_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_FILL;
         req_q      <= 1'b0;
         bank_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         addr_q     <= {ADDR_W{1'b0}};
         data_q     <= {WORD_W{1'b0}};
         done_q     <= 1'b0;
         underrun_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         bank_q     <= bank_d;
         wr_en_q    <= wr_en_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   assign o_wr_bank      = bank_q;
   assign o_wr_en        = wr_en_q;
   assign o_addr_write   = addr_q;
   assign o_data_line    = data_q;
   assign o_frame_done   = done_q;
   assign o_underrun_cnt = underrun_q;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader with a 4-word frame; RAM writes are
// checked against a queue of expected {addr, bank, word, done} records.
module tb_frame_loader;

   localparam int WPF = 4;
   localparam int AW  = 12;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          s_valid;
   logic          s_ready;
   logic [8:0]    s_pixel;
   logic          s_last;
   logic          i_require_data;
   logic          o_wr_bank;
   logic          o_wr_en;
   logic [AW-1:0] o_addr_write;
   logic [35:0]   o_data_line;
   logic          o_frame_done;
   logic [7:0]    o_underrun_cnt;

   always #5 i_clk = ~i_clk;

   frame_loader #(.WORDS_PER_FRAME(WPF), .ADDR_W(AW)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_pixel       (s_pixel),
      .s_last        (s_last),
      .i_require_data(i_require_data),
      .o_wr_bank     (o_wr_bank),
      .o_wr_en       (o_wr_en),
      .o_addr_write  (o_addr_write),
      .o_data_line   (o_data_line),
      .o_frame_done  (o_frame_done),
      .o_underrun_cnt(o_underrun_cnt)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          bank;
      logic [35:0]   data;
      logic          done;
   } wr_t;

   typedef struct {
      logic [8:0]  pix[4];
      logic [35:0] word;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[4];
   int   n_vec = 0;
   int   n_err = 0;
   logic req = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Every write strobe is matched against the next expected record.
   always @(negedge i_clk) begin
      wr_t e;
      if (!i_rst && o_wr_en) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", o_addr_write, o_data_line);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", o_addr_write, e.addr);
            check("wr_bank", o_wr_bank, e.bank);
            check("wr_data", o_data_line, e.data);
            check("wr_done", o_frame_done, e.done);
         end
      end else if (!i_rst && o_frame_done) begin
         n_vec++;
         n_err++;
         $display("FAIL stray_frame_done: got 1 without wr_en, expected 0");
      end
   end

   // Entered at a negedge; returns at a negedge after acceptance or after max_wait tries.
   task automatic send(input logic [8:0] pix, input logic last, input int max_wait, output bit ok);
      ok      = 1'b0;
      s_valid = 1'b1;
      s_pixel = pix;
      s_last  = last;
      for (int i = 0; i < max_wait && !ok; i++) begin
         #1;
         if (s_ready) ok = 1'b1;
         @(negedge i_clk);
      end
   endtask

   task automatic send_word(input int vi, input logic [AW-1:0] addr, input logic bank,
                            input logic done, input logic last);
      bit ok;
      for (int l = 0; l < 4; l++) begin
         if (l == 3) exp_q.push_back('{addr: addr, bank: bank, data: vecs[vi].word, done: done});
         send(vecs[vi].pix[l], (l == 3) ? last : 1'b0, 8, ok);
         check("pixel_accepted", ok, 1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic toggle_req();
      req            = ~req;
      i_require_data = req;
   endtask

   initial begin
      bit ok;
      int accepted;

      vecs[0].pix = '{9'h1FF, 9'h000, 9'h0AA, 9'h155};
      vecs[0].word = {9'h0AA, 9'h155, 9'h1FF, 9'h000};
      vecs[1].pix = '{9'h123, 9'h045, 9'h1C7, 9'h038};
      vecs[1].word = {9'h1C7, 9'h038, 9'h123, 9'h045};
      vecs[2].pix = '{9'h001, 9'h002, 9'h004, 9'h008};
      vecs[2].word = {9'h004, 9'h008, 9'h001, 9'h002};
      vecs[3].pix = '{9'h100, 9'h080, 9'h040, 9'h020};
      vecs[3].word = {9'h040, 9'h020, 9'h100, 9'h080};

      // Reset values, with s_valid high to show ready is held low in reset.
      i_rst = 1'b1; s_valid = 1'b1; s_pixel = 9'h1FF; s_last = 1'b0; i_require_data = 1'b0;
      @(negedge i_clk); @(negedge i_clk);
      check("rst_bank", o_wr_bank, 0);
      check("rst_wr_en", o_wr_en, 0);
      check("rst_addr", o_addr_write, 0);
      check("rst_data", o_data_line, 0);
      check("rst_done", o_frame_done, 0);
      check("rst_underrun", o_underrun_cnt, 0);
      check("rst_ready", s_ready, 0);
      s_valid = 1'b0;
      i_rst   = 1'b0;
      @(negedge i_clk);

      // Full frame of four words back to back, then extra pixels must be refused.
      for (int v = 0; v < 4; v++) send_word(v, AW'(v), 1'b0, (v == 3), 1'b0);
      accepted = 0;
      for (int k = 0; k < 4; k++) begin
         send(9'h0F0 + 9'(k), 1'b0, 3, ok);
         if (ok) accepted++;
      end
      s_valid = 1'b0;
      check("extra_accepted", accepted, 0);
      check("full_ready", s_ready, 0);
      check("full_addr", o_addr_write, WPF - 1);

      // Swap after a completed frame: no underrun.
      toggle_req();
      #1 check("swap_cycle_ready", s_ready, 0);
      @(negedge i_clk);
      #1;
      check("swap_bank", o_wr_bank, 1);
      check("swap_addr", o_addr_write, 0);
      check("swap_ready", s_ready, 1);
      check("swap_underrun", o_underrun_cnt, 0);

      // Swap after 6 pixels: underrun, partial word discarded.
      send_word(1, 12'd0, 1'b1, 1'b0, 1'b0);
      send(vecs[2].pix[0], 1'b0, 8, ok);
      check("pixel_accepted", ok, 1);
      send(vecs[2].pix[1], 1'b0, 8, ok);
      check("pixel_accepted", ok, 1);
      s_valid = 1'b0;
      toggle_req();
      @(negedge i_clk);
      #1;
      check("underrun_cnt", o_underrun_cnt, 1);
      check("underrun_bank", o_wr_bank, 0);
      check("underrun_addr", o_addr_write, 0);
      send_word(2, 12'd0, 1'b0, 1'b0, 1'b0);

      // Short final word: s_last on the 3rd pixel, lane 3 zero-filled.
      exp_q.push_back('{addr: 12'd1, bank: 1'b0, data: {9'h0EF, 9'h000, 9'h1AB, 9'h0CD}, done: 1'b1});
      send(9'h1AB, 1'b0, 8, ok); check("pixel_accepted", ok, 1);
      send(9'h0CD, 1'b0, 8, ok); check("pixel_accepted", ok, 1);
      send(9'h0EF, 1'b1, 8, ok); check("pixel_accepted", ok, 1);
      s_valid = 1'b0; s_last = 1'b0;
      #1 check("last_ready", s_ready, 0);
      @(negedge i_clk); @(negedge i_clk);
      #1 check("last_addr_hold", o_addr_write, 1);

      // s_last on a word boundary: exactly one word, no trailing empty word.
      toggle_req();
      @(negedge i_clk);
      send_word(3, 12'd0, 1'b1, 1'b1, 1'b1);
      @(negedge i_clk); @(negedge i_clk);
      #1 check("boundary_ready", s_ready, 0);
      check("boundary_underrun", o_underrun_cnt, 1);

      // Back-to-back swaps saturate the underrun counter.
      for (int k = 0; k < 300; k++) begin
         toggle_req();
         @(negedge i_clk);
      end
      @(negedge i_clk);
      #1 check("underrun_sat", o_underrun_cnt, 255);
      check("sat_bank", o_wr_bank, 1);

      // Reset mid-fill while a swap and a 4th pixel arrive together.
      send(9'h011, 1'b0, 8, ok); check("pixel_accepted", ok, 1);
      send(9'h022, 1'b0, 8, ok); check("pixel_accepted", ok, 1);
      send(9'h033, 1'b0, 8, ok); check("pixel_accepted", ok, 1);
      s_pixel = 9'h044;
      toggle_req();
      i_rst = 1'b1;
      #1;
      check("mid_rst_bank", o_wr_bank, 0);
      check("mid_rst_wr_en", o_wr_en, 0);
      check("mid_rst_addr", o_addr_write, 0);
      check("mid_rst_data", o_data_line, 0);
      check("mid_rst_done", o_frame_done, 0);
      check("mid_rst_underrun", o_underrun_cnt, 0);
      check("mid_rst_ready", s_ready, 0);
      req = 1'b0;
      i_require_data = 1'b0;
      s_valid = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      send_word(0, 12'd0, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge i_clk);
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
Back-buffer write sequencer for the double-buffered HUB75 panel driver. It accepts a stream of RGB333 pixels on a valid/ready handshake and packs four pixels into each 36-bit RAM word. It writes those words sequentially into whichever frame RAM the display is not reading. It tracks the display's buffer swaps through the require-data toggle, retargets the idle bank on each swap, and flags frames that were not fully loaded in time.

Parameters:
WORDS_PER_FRAME, 3360, number of 36-bit words per frame; must be ≤ 4096.
ADDR_W, 12, write address width; matches the RAM addrWrite width.

Ports:
i_clk  input  1  system clock, same clock as the panel driver.
i_rst  input  1  asynchronous, active-high reset.
s_valid  input  1  pixel valid.
s_ready  output  1  pixel accepted when s_valid && s_ready.
s_pixel  input  9  RGB333 pixel: R[8:6], G[5:3], B[2:0].
s_last  input  1  marks the final pixel of a frame; qualified by the handshake.
i_require_data  input  1  level that toggles on every display buffer swap.
o_wr_bank  output  1  bank currently written; drives the driver's wr input (1 = RAM1, 0 = RAM2).
o_wr_en  output  1  one-cycle word write strobe.
o_addr_write  output  ADDR_W  word address for the current write.
o_data_line  output  36  packed word; the top level drives both dataLine1 and dataLine2 from it.
o_frame_done  output  1  one-cycle pulse when a frame has been completely written.
o_underrun_cnt  output  8  saturating count of swaps that arrived before the frame completed.

Behaviour:
- Reset values:
  - o_wr_bank=0, o_wr_en=0, o_addr_write=0, o_data_line=0, o_frame_done=0, o_underrun_cnt=0.
  - state=S_FILL, lane=0, req_q=0, s_ready=0 while reset is asserted.
- Swap event: swap_evt = i_require_data ^ req_q. req_q is registered every cycle and reset to 0.
- States:
  - S_FILL:
    - s_ready = ~swap_evt.
    - Each accepted pixel goes to lane 0..3. Packing: lane0 → [17:9], lane1 → [8:0], lane2 → [35:27], lane3 → [26:18].
    - On accepting lane 3, or any lane with s_last=1, the next cycle shows o_wr_en=1 with the packed word and current o_addr_write.
    - Lanes not yet filled in that word are written as zero. lane then resets to 0.
    - The address increments in the cycle after the strobe.
    - If the written word is at address WORDS_PER_FRAME-1, or s_last was set, go to S_FULL and pulse o_frame_done together with o_wr_en.
  - S_FULL:
    - s_ready=0.
    - Wait for swap_evt.
- On swap_evt in any state:
  - Next cycle: o_wr_bank toggles, o_addr_write=0, lane=0, partial word discarded, state=S_FILL.
  - If the state was S_FILL when the swap arrived, o_underrun_cnt increments, saturating at 255.
- Simultaneous events:
  - The swap takes priority. s_ready is low in the swap_evt cycle, so no pixel is lost silently.
  - A word strobe already scheduled in that same cycle still completes to the old bank and address.
- Throughput: one pixel per cycle. Write latency is 1 cycle from the 4th accepted pixel to o_wr_en.
- s_last on a word boundary produces no extra empty word.
- Address never exceeds WORDS_PER_FRAME-1. Extra pixels are back-pressured, never wrapped.
- Reset mid-frame: everything returns to reset values immediately. Partially written RAM contents are not cleared.

Decomposition:
- Package lcd_pkg:
  - State encoding: S_FILL, S_FULL.
  - Lane bit-slice constants for packing.
  - RGB333 field widths.
- One natural sub-module: pixel_packer (lane counter plus 36-bit assembly register and zero fill).
- Bank/address/state control stays in frame_loader.

Test Plan:
- Reset, then stream 8 pixels 0x1FF,0x000,0x0AA,0x155,… with s_valid held high → two strobes at addr 0 and 1. Word 0 = {0x0AA,0x155,0x1FF,0x000} in lanes [35:27],[26:18],[17:9],[8:0]. o_wr_bank=0.
- WORDS_PER_FRAME=4, stream 20 pixels → 4 strobes, o_frame_done on the 4th. s_ready drops and stays low. Pixels 17-20 are not accepted.
- After the frame completes, toggle i_require_data → next cycle o_wr_bank=1, addr=0, s_ready=1. o_underrun_cnt stays 0.
- Toggle i_require_data after 6 pixels → o_underrun_cnt=1, bank flips, addr=0. The partial word is not written. The 1st strobe of the new fill is at addr 0.
- 3 pixels with s_last on the 3rd → one strobe with lane3 bits [26:18]=0, plus o_frame_done. State goes to S_FULL.
- Assert i_rst during a fill, with a swap arriving on the same cycle as an accepted 4th pixel → all outputs return to reset values. After release, the first pixel lands in lane0 at addr 0, bank 0.
